// File: rtl/piano_input_pkg.sv
// rtl/piano_input_pkg.sv - shared mode encodings, key indices and helpers for the piano input conditioner
package piano_input_pkg;

    // Encoding doubles as {learn_song_button, free_play_button}
    typedef enum logic [1:0] {
        MODE_HOME  = 2'b00,
        MODE_FREE  = 2'b01,
        MODE_LEARN = 2'b10
    } mode_e;

    localparam int NUM_KEYS = 7;
    localparam int KEY_C = 0;
    localparam int KEY_D = 1;
    localparam int KEY_E = 2;
    localparam int KEY_F = 3;
    localparam int KEY_G = 4;
    localparam int KEY_A = 5;
    localparam int KEY_B = 6;

    function automatic logic [2:0] lowest_idx(input logic [NUM_KEYS-1:0] keys);
        lowest_idx = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) lowest_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser followed by a stable-count debouncer for one input bit
module input_debouncer
    import piano_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the accepted value
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/piano_input_conditioner.sv
// rtl/piano_input_conditioner.sv - debounced keys/buttons, screen-mode FSM and mode-gated key levels; IDLE_TIMEOUT_EN adds auto-return to home
module piano_input_conditioner
    import piano_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned TIMEOUT_CYCLES  = 750000000,
    parameter int unsigned TO_W            = 30
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                btn_free_raw,
    input  logic                btn_learn_raw,
    input  logic                btn_home_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                note_valid,
    output logic [2:0]          note_idx,
    output logic                free_play_button,
    output logic                learn_song_button
);

    logic [9:0]          raw_all, stable_all;
    logic [NUM_KEYS-1:0] stable_keys;
    logic [2:0]          stable_btn, btn_prev_q, btn_ev;
    logic                free_ev, learn_ev, home_ev, timeout;
    mode_e               state_q, state_d;
    logic [NUM_KEYS-1:0] key_out_q, key_out_d, key_press_q;
    logic                note_valid_q;
    logic [2:0]          note_idx_q;

    assign raw_all = {btn_home_raw, btn_learn_raw, btn_free_raw, key_raw};

    for (genvar i = 0; i < 10; i++) begin : g_db
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_i   (vga_clk),
            .rst_i   (reset),
            .raw_i   (raw_all[i]),
            .stable_o(stable_all[i])
        );
    end

    assign stable_keys = stable_all[NUM_KEYS-1:0];
    assign stable_btn  = stable_all[9:7];
    assign btn_ev      = stable_btn & ~btn_prev_q;
    assign free_ev     = btn_ev[0];
    assign learn_ev    = btn_ev[1];
    assign home_ev     = btn_ev[2];

`ifdef IDLE_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;

    // Any key held or button event restarts the idle window
    always_comb begin
        to_d    = '0;
        timeout = 1'b0;
        if (state_q != MODE_HOME && key_out_q == '0 && btn_ev == '0) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) to_q <= '0;
        else       to_q <= to_d;
    end
`else
    assign timeout = (TO_W == 0) && (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_HOME: begin
                if (free_ev)       state_d = MODE_FREE;
                else if (learn_ev) state_d = MODE_LEARN;
            end
            MODE_FREE: begin
                if (home_ev)       state_d = MODE_HOME;
                else if (learn_ev) state_d = MODE_LEARN;
                else if (timeout)  state_d = MODE_HOME;
            end
            MODE_LEARN: begin
                if (home_ev)       state_d = MODE_HOME;
                else if (free_ev)  state_d = MODE_FREE;
                else if (timeout)  state_d = MODE_HOME;
            end
            default: state_d = MODE_HOME;
        endcase
    end

    assign key_out_d = stable_keys & {NUM_KEYS{state_q != MODE_HOME}};

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= MODE_HOME;
            btn_prev_q   <= '0;
            key_out_q    <= '0;
            key_press_q  <= '0;
            note_valid_q <= 1'b0;
            note_idx_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= stable_btn;
            key_out_q    <= key_out_d;
            key_press_q  <= key_out_d & ~key_out_q;
            note_valid_q <= |key_out_d;
            note_idx_q   <= lowest_idx(key_out_d);
        end
    end

    assign key_out           = key_out_q;
    assign key_press         = key_press_q;
    assign note_valid        = note_valid_q;
    assign note_idx          = note_idx_q;
    assign free_play_button  = state_q[0];
    assign learn_song_button = state_q[1];

endmodule

// File: tb/tb_piano_input_conditioner.sv
// tb/tb_piano_input_conditioner.sv - table-driven self-checking bench for piano_input_conditioner
module tb_piano_input_conditioner;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [6:0] key_raw;
    logic       btn_free_raw, btn_learn_raw, btn_home_raw;
    logic [6:0] key_out, key_press;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       free_play_button, learn_song_button;

    int checks = 0;
    int errors = 0;

    piano_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .TIMEOUT_CYCLES (20),
        .TO_W           (5)
    ) dut (
        .vga_clk          (vga_clk),
        .reset            (reset),
        .key_raw          (key_raw),
        .btn_free_raw     (btn_free_raw),
        .btn_learn_raw    (btn_learn_raw),
        .btn_home_raw     (btn_home_raw),
        .key_out          (key_out),
        .key_press        (key_press),
        .note_valid       (note_valid),
        .note_idx         (note_idx),
        .free_play_button (free_play_button),
        .learn_song_button(learn_song_button)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [6:0] key;
        logic [2:0] btn;     // {home, learn, free}
        int         ticks;
        logic [6:0] out;
        logic [6:0] press;
        logic       valid;
        logic [2:0] idx;
        logic       free;
        logic       learn;
    } vec_t;

    vec_t vecs[20];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, got, exp);
        end
    endtask

    task automatic chk_all(input int tag, input logic [6:0] e_out, input logic [6:0] e_press,
                           input logic e_valid, input logic [2:0] e_idx,
                           input logic e_free, input logic e_learn);
        chk("key_out",    tag, {1'b0, key_out},   {1'b0, e_out});
        chk("key_press",  tag, {1'b0, key_press}, {1'b0, e_press});
        chk("note_valid", tag, {7'd0, note_valid}, {7'd0, e_valid});
        chk("note_idx",   tag, {5'd0, note_idx},  {5'd0, e_idx});
        chk("free_btn",   tag, {7'd0, free_play_button},  {7'd0, e_free});
        chk("learn_btn",  tag, {7'd0, learn_song_button}, {7'd0, e_learn});
    endtask

    initial begin
        //             key    btn   n   out    press  v  idx  fr lr
        vecs[0]  = '{7'h00, 3'b000, 1, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[1]  = '{7'h01, 3'b000, 10, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[2]  = '{7'h01, 3'b001, 6, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[3]  = '{7'h01, 3'b001, 1, 7'h00, 7'h00, 0, 3'd0, 1, 0};
        vecs[4]  = '{7'h01, 3'b001, 1, 7'h01, 7'h01, 1, 3'd0, 1, 0};
        vecs[5]  = '{7'h01, 3'b001, 1, 7'h01, 7'h00, 1, 3'd0, 1, 0};
        vecs[6]  = '{7'h14, 3'b001, 6, 7'h01, 7'h00, 1, 3'd0, 1, 0};
        vecs[7]  = '{7'h14, 3'b001, 1, 7'h14, 7'h14, 1, 3'd2, 1, 0};
        vecs[8]  = '{7'h14, 3'b001, 1, 7'h14, 7'h00, 1, 3'd2, 1, 0};
        vecs[9]  = '{7'h14, 3'b000, 8, 7'h14, 7'h00, 1, 3'd2, 1, 0};
        vecs[10] = '{7'h14, 3'b010, 6, 7'h14, 7'h00, 1, 3'd2, 1, 0};
        vecs[11] = '{7'h14, 3'b010, 1, 7'h14, 7'h00, 1, 3'd2, 0, 1};
        vecs[12] = '{7'h14, 3'b111, 6, 7'h14, 7'h00, 1, 3'd2, 0, 1};
        vecs[13] = '{7'h14, 3'b111, 1, 7'h14, 7'h00, 1, 3'd2, 0, 0};
        vecs[14] = '{7'h14, 3'b111, 1, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[15] = '{7'h14, 3'b000, 8, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[16] = '{7'h14, 3'b011, 6, 7'h00, 7'h00, 0, 3'd0, 0, 0};
        vecs[17] = '{7'h14, 3'b011, 1, 7'h00, 7'h00, 0, 3'd0, 1, 0};
        vecs[18] = '{7'h14, 3'b011, 1, 7'h14, 7'h14, 1, 3'd2, 1, 0};
        vecs[19] = '{7'h14, 3'b000, 8, 7'h14, 7'h00, 1, 3'd2, 1, 0};

        reset = 1'b1;
        key_raw = 7'h00;
        {btn_home_raw, btn_learn_raw, btn_free_raw} = 3'b000;
        tick(3);
        chk_all(100, 7'h00, 7'h00, 0, 3'd0, 0, 0);
        reset = 1'b0;

        for (int v = 0; v < 20; v++) begin
            key_raw = vecs[v].key;
            {btn_home_raw, btn_learn_raw, btn_free_raw} = vecs[v].btn;
            tick(vecs[v].ticks);
            chk_all(v, vecs[v].out, vecs[v].press, vecs[v].valid, vecs[v].idx,
                    vecs[v].free, vecs[v].learn);
        end

        // 3-cycle glitch on key B must never reach the stable value
        key_raw = 7'h54;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("glitch_out", 200 + i, {1'b0, key_out}, 8'h14);
            chk("glitch_press", 200 + i, {1'b0, key_press}, 8'h00);
        end
        key_raw = 7'h14;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_out", 210 + i, {1'b0, key_out}, 8'h14);
            chk("glitch_press", 210 + i, {1'b0, key_press}, 8'h00);
        end

        // Release all keys, then let the mode sit idle
        key_raw = 7'h00;
`ifdef IDLE_TIMEOUT_EN
        tick(26);
        chk("timeout_before", 300, {7'd0, free_play_button}, 8'd1);
        tick(1);
        chk("timeout_home", 301, {7'd0, free_play_button}, 8'd0);
`else
        tick(40);
        chk("idle_hold", 300, {7'd0, free_play_button}, 8'd1);
        chk("idle_out", 301, {1'b0, key_out}, 8'h00);
`endif

        // Reset in the middle of a key debounce
        key_raw = 7'h01;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk_all(400, 7'h00, 7'h00, 0, 3'd0, 0, 0);
        reset = 1'b0;
        tick(20);
        chk_all(401, 7'h00, 7'h00, 0, 3'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
